fp_add_rob: RTL and testbench

- In-order result collector directly downstream of the tensor fp_adder (fpnew core).
- Upstream issue logic allocates a tag per operation before driving the adder.
- The adder returns results tagged, possibly out of order across lanes/latency classes; this block stores them by tag.
- Releases results strictly in allocation order over a valid/ready stream to the tensor writeback stage.

---
 rtl/tensor_fp_pkg.sv | 13 +
 rtl/fp_add_rob.sv | 115 +++++++++++
 tb/tb_fp_add_rob.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_fp_pkg.sv
// Shared definitions for the tensor floating-point add path (fp_adder and its result collector).
package tensor_fp_pkg;

    localparam int FP_STATUSW   = 5;
    localparam int FP_DATAW     = 64;
    localparam int FP_ROB_DEPTH = 8;

    typedef struct packed {
        logic [FP_STATUSW-1:0] status;
        logic [FP_DATAW-1:0]   data;
    } rob_slot_t;

endpackage

// File: rtl/fp_add_rob.sv
// In-order result collector behind the tensor fp_adder: stores tagged results, releases in tag order.
// Optional sticky flag accumulator: define FP_ADD_ROB_FFLAGS_EN.
module fp_add_rob
    import tensor_fp_pkg::*;
#(
    parameter int DATAW   = FP_DATAW,
    parameter int DEPTH   = FP_ROB_DEPTH,
    parameter int STATUSW = FP_STATUSW,
    localparam int TAGW   = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    output logic [TAGW-1:0]    alloc_tag_o,
    input  logic               res_valid_i,
    output logic               res_ready_o,
    input  logic [TAGW-1:0]    res_tag_i,
    input  logic [DATAW-1:0]   res_data_i,
    input  logic [STATUSW-1:0] res_status_i,
`ifdef FP_ADD_ROB_FFLAGS_EN
    output logic [STATUSW-1:0] fflags_o,
    input  logic               fflags_clr_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATAW-1:0]   out_data_o,
    output logic [STATUSW-1:0] out_status_o,
    output logic [TAGW:0]      occupancy_o,
    output logic               bad_tag_o
);

    logic [TAGW:0]      head_q, tail_q;
    logic [DEPTH-1:0]   filled_q;
    rob_slot_t          slots_q [DEPTH];
    logic               bad_tag_q;
    logic               res_ready_q;

    logic [TAGW-1:0]    head_idx;
    logic               empty, full;
    logic               do_alloc, do_pop, do_write, write_legal;
    logic [DEPTH-1:0]   pop_mask, write_mask;

    // A tag is writable only if it lies in the allocated window [head, tail) and is still empty.
    function automatic logic tag_legal(input logic [TAGW-1:0]  tag,
                                       input logic [TAGW-1:0]  head,
                                       input logic [TAGW:0]    occ,
                                       input logic [DEPTH-1:0] filled);
        logic [TAGW-1:0] off;
        off = tag - head;
        return ({1'b0, off} < occ) && !filled[tag];
    endfunction

    assign head_idx    = head_q[TAGW-1:0];
    assign empty       = (head_q == tail_q);
    assign full        = (head_q[TAGW-1:0] == tail_q[TAGW-1:0]) && (head_q[TAGW] != tail_q[TAGW]);
    assign occupancy_o = tail_q - head_q;

    assign alloc_ready_o = !full;
    assign alloc_tag_o   = tail_q[TAGW-1:0];
    assign res_ready_o   = res_ready_q;
    assign bad_tag_o     = bad_tag_q;

    assign out_valid_o  = filled_q[head_idx] && !empty;
    assign out_data_o   = DATAW'(slots_q[head_idx].data);
    assign out_status_o = STATUSW'(slots_q[head_idx].status);

    assign write_legal = tag_legal(res_tag_i, head_idx, occupancy_o, filled_q);
    assign do_alloc    = alloc_valid_i && alloc_ready_o;
    assign do_pop      = out_valid_o && out_ready_i;
    assign do_write    = res_valid_i && res_ready_q && write_legal;

    assign pop_mask   = DEPTH'(do_pop) << head_idx;
    assign write_mask = DEPTH'(do_write) << res_tag_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q      <= '0;
            tail_q      <= '0;
            filled_q    <= '0;
            bad_tag_q   <= 1'b0;
            res_ready_q <= 1'b0;
        end else begin
            res_ready_q <= 1'b1;
            bad_tag_q   <= res_valid_i && res_ready_q && !write_legal;
            filled_q    <= (filled_q & ~pop_mask) | write_mask;
            if (do_alloc) tail_q <= tail_q + 1'b1;
            if (do_pop)   head_q <= head_q + 1'b1;
        end
    end

    // Payload storage carries no reset; filled_q alone says whether a slot is meaningful.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            slots_q[res_tag_i].data   <= FP_DATAW'(res_data_i);
            slots_q[res_tag_i].status <= FP_STATUSW'(res_status_i);
        end
    end

`ifdef FP_ADD_ROB_FFLAGS_EN
    logic [STATUSW-1:0] fflags_q;

    // A clear and a pop in the same cycle: the popped flags survive the clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= (fflags_clr_i ? '0 : fflags_q) | (do_pop ? out_status_o : '0);
        end
    end

    assign fflags_o = fflags_q;
`endif

endmodule

// File: tb/tb_fp_add_rob.sv
// Directed bench for fp_add_rob with an allocation-order scoreboard on the output stream.
module tb_fp_add_rob;

    localparam int DATAW   = 64;
    localparam int DEPTH   = 8;
    localparam int STATUSW = 5;
    localparam int TAGW    = 3;
    localparam int EW      = DATAW + STATUSW;

    logic               clk, rst_n;
    logic               alloc_valid, alloc_ready;
    logic [TAGW-1:0]    alloc_tag;
    logic               res_valid, res_ready;
    logic [TAGW-1:0]    res_tag;
    logic [DATAW-1:0]   res_data;
    logic [STATUSW-1:0] res_status;
    logic               out_valid, out_ready;
    logic [DATAW-1:0]   out_data;
    logic [STATUSW-1:0] out_status;
    logic [TAGW:0]      occupancy;
    logic               bad_tag;
`ifdef FP_ADD_ROB_FFLAGS_EN
    logic [STATUSW-1:0] fflags;
    logic               fflags_clr;
`endif

    int errors  = 0;
    int checks  = 0;
    int pop_cnt = 0;

    logic [EW-1:0]      exp_q[$];
    logic [DATAW-1:0]   pend_data [DEPTH];
    logic [STATUSW-1:0] pend_st [DEPTH];

    fp_add_rob dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .alloc_valid_i (alloc_valid),
        .alloc_ready_o (alloc_ready),
        .alloc_tag_o   (alloc_tag),
        .res_valid_i   (res_valid),
        .res_ready_o   (res_ready),
        .res_tag_i     (res_tag),
        .res_data_i    (res_data),
        .res_status_i  (res_status),
`ifdef FP_ADD_ROB_FFLAGS_EN
        .fflags_o      (fflags),
        .fflags_clr_i  (fflags_clr),
`endif
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_status_o  (out_status),
        .occupancy_o   (occupancy),
        .bad_tag_o     (bad_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Allocates one slot and records the result the adder will later return for it.
    task automatic alloc_one(input logic [STATUSW-1:0] st, output logic [TAGW-1:0] tag);
        logic [DATAW-1:0] d;
        d = {$urandom, $urandom};
        check("alloc_ready", EW'(alloc_ready), EW'(1));
        tag = alloc_tag;
        pend_data[tag] = d;
        pend_st[tag] = st;
        exp_q.push_back({st, d});
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic write_res(input logic [TAGW-1:0] tag);
        res_valid  = 1'b1;
        res_tag    = tag;
        res_data   = pend_data[tag];
        res_status = pend_st[tag];
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (occupancy == 0) break;
            tick();
        end
        check("drain_occupancy", EW'(occupancy), EW'(0));
        check("drain_queue", EW'(exp_q.size()), EW'(0));
    endtask

    // Scoreboard: every handshake on the output must match the oldest allocation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                check("pop_unexpected", EW'(1), EW'(0));
            end else begin
                check("pop_data", {out_status, out_data}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [TAGW-1:0] t [4];
        logic [TAGW-1:0] ft [DEPTH];
        logic [TAGW-1:0] tn;
        logic [EW-1:0]   snap;
        int              base;

        rst_n = 1'b0; alloc_valid = 1'b0; res_valid = 1'b0; res_tag = '0;
        res_data = '0; res_status = '0; out_ready = 1'b0;
`ifdef FP_ADD_ROB_FFLAGS_EN
        fflags_clr = 1'b0;
`endif
        repeat (2) tick();
        check("rst_out_valid", EW'(out_valid), EW'(0));
        check("rst_occupancy", EW'(occupancy), EW'(0));
        check("rst_bad_tag", EW'(bad_tag), EW'(0));
        check("rst_res_ready", EW'(res_ready), EW'(0));
        check("rst_alloc_tag", EW'(alloc_tag), EW'(0));
        rst_n = 1'b1;
        tick();
        check("res_ready_after_rst", EW'(res_ready), EW'(1));
        check("alloc_ready_after_rst", EW'(alloc_ready), EW'(1));

        // In-order returns, consumer always ready.
        out_ready = 1'b1;
        base = pop_cnt;
        for (int i = 0; i < 3; i++) alloc_one(STATUSW'($urandom_range(0, 31)), t[i]);
        check("inorder_alloc_tags", EW'({t[0], t[1], t[2]}), EW'({3'd0, 3'd1, 3'd2}));
        check("inorder_no_valid_yet", EW'(out_valid), EW'(0));
        for (int i = 0; i < 3; i++) begin
            write_res(t[i]);
            tick();
            check("inorder_latency", EW'(out_valid), EW'(1));
        end
        res_valid = 1'b0;
        tick();
        check("inorder_occupancy", EW'(occupancy), EW'(0));
        check("inorder_pops", EW'(pop_cnt - base), EW'(3));

        // Out-of-order returns 3,1,2,0.
        for (int i = 0; i < 4; i++) alloc_one(STATUSW'($urandom_range(0, 31)), t[i]);
        check("ooo_occupancy", EW'(occupancy), EW'(4));
        base = pop_cnt;
        write_res(t[3]); tick(); check("ooo_wait3", EW'(out_valid), EW'(0));
        write_res(t[1]); tick(); check("ooo_wait1", EW'(out_valid), EW'(0));
        write_res(t[2]); tick(); check("ooo_wait2", EW'(out_valid), EW'(0));
        write_res(t[0]); tick(); check("ooo_head_ready", EW'(out_valid), EW'(1));
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ooo_back_to_back", EW'(out_valid), EW'(1));
        end
        tick();
        check("ooo_done_valid", EW'(out_valid), EW'(0));
        check("ooo_pops", EW'(pop_cnt - base), EW'(4));

        // Reset with work in flight discards everything.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) alloc_one(STATUSW'($urandom_range(0, 31)), t[i]);
        write_res(t[0]); tick();
        write_res(t[1]); tick();
        res_valid = 1'b0;
        check("midrst_valid_before", EW'(out_valid), EW'(1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", EW'(out_valid), EW'(0));
        check("midrst_occupancy", EW'(occupancy), EW'(0));
        check("midrst_alloc_tag", EW'(alloc_tag), EW'(0));
        tick();
        rst_n = 1'b1;
        tick();
        write_res(3'd0);
        tick();
        res_valid = 1'b0;
        check("post_rst_write_bad", EW'(bad_tag), EW'(1));
        check("post_rst_occupancy", EW'(occupancy), EW'(0));

        // Fill to DEPTH, then backpressure.
        for (int i = 0; i < DEPTH; i++) alloc_one(STATUSW'($urandom_range(0, 31)), ft[i]);
        check("full_alloc_ready", EW'(alloc_ready), EW'(0));
        check("full_occupancy", EW'(occupancy), EW'(DEPTH));
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        check("full_alloc_blocked", EW'(occupancy), EW'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            write_res(ft[(i * 3) % DEPTH]);
            tick();
        end
        res_valid = 1'b0;
        check("full_head_valid", EW'(out_valid), EW'(1));
        snap = {out_status, out_data};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", EW'(out_valid), EW'(1));
            check("hold_stable", {out_status, out_data}, snap);
        end
        out_ready = 1'b1;
        alloc_valid = 1'b1;
        check("full_pop_no_bypass", EW'(alloc_ready), EW'(0));
        tick();
        out_ready = 1'b0;
        alloc_valid = 1'b0;
        check("after_pop_alloc_ready", EW'(alloc_ready), EW'(1));
        check("after_pop_occupancy", EW'(occupancy), EW'(DEPTH - 1));
        check("after_pop_alloc_tag", EW'(alloc_tag), EW'(0));
        alloc_one(STATUSW'($urandom_range(0, 31)), tn);
        check("wrap_occupancy", EW'(occupancy), EW'(DEPTH));
        write_res(tn);
        tick();
        res_valid = 1'b0;
        check("wrap_write_ok", EW'(bad_tag), EW'(0));
        drain();

        // Illegal result writes.
        out_ready = 1'b0;
        alloc_one(STATUSW'($urandom_range(0, 31)), t[0]);
        alloc_one(STATUSW'($urandom_range(0, 31)), t[1]);
        res_valid = 1'b1; res_tag = t[0] + 3'd4; res_data = '1; res_status = '1;
        tick();
        res_valid = 1'b0;
        check("unalloc_bad_pulse", EW'(bad_tag), EW'(1));
        check("unalloc_occupancy", EW'(occupancy), EW'(2));
        check("unalloc_no_valid", EW'(out_valid), EW'(0));
        tick();
        check("unalloc_pulse_once", EW'(bad_tag), EW'(0));
        write_res(t[1]);
        tick();
        check("legal_no_bad", EW'(bad_tag), EW'(0));
        res_data = ~pend_data[t[1]];
        res_status = ~pend_st[t[1]];
        tick();
        res_valid = 1'b0;
        check("dup_bad_pulse", EW'(bad_tag), EW'(1));
        write_res(t[0]);
        tick();
        res_valid = 1'b0;
        drain();

`ifdef FP_ADD_ROB_FFLAGS_EN
        out_ready = 1'b0;
        fflags_clr = 1'b1;
        tick();
        fflags_clr = 1'b0;
        check("fflags_cleared", EW'(fflags), EW'(0));
        alloc_one(5'b00001, t[0]);
        alloc_one(5'b10000, t[1]);
        write_res(t[0]); tick();
        write_res(t[1]); tick();
        res_valid = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        check("fflags_sticky_or", EW'(fflags), EW'(5'b10001));
        alloc_one(5'b00100, t[2]);
        write_res(t[2]); tick();
        res_valid = 1'b0;
        fflags_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        fflags_clr = 1'b0;
        out_ready = 1'b0;
        check("fflags_clr_with_pop", EW'(fflags), EW'(5'b00100));
`endif

        check("final_queue_empty", EW'(exp_q.size()), EW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
